// File: rtl/mio_bus_arbiter.sv
// Two-master (CPU read/write, DMA read-only) arbiter onto a single memory bus.
// Round-robin on contention, per-access wait timeout, one-cycle ready pulse per access.
module mio_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic [2:0]  state_out
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CPU_BUSY = 3'd1;
  localparam logic [2:0] S_DMA_BUSY = 3'd2;
  localparam logic [2:0] S_CPU_DONE = 3'd3;
  localparam logic [2:0] S_DMA_DONE = 3'd4;

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // Last BUSY cycle index without ack; the timeout fires as the count reaches MAX_WAIT.
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  logic [2:0]    r_state, w_state;
  logic          r_last_dma, w_last_dma;
  logic [CW-1:0] r_wait, w_wait;
  logic          r_we, w_we;
  logic [31:0]   r_addr, w_addr;
  logic [31:0]   r_wdata, w_wdata;
  logic [31:0]   r_cpu_rdata, w_cpu_rdata;
  logic [31:0]   r_dma_rdata, w_dma_rdata;
  logic          r_err, w_err;
  logic          w_busy;

  always_comb begin
    w_state     = r_state;
    w_last_dma  = r_last_dma;
    w_wait      = r_wait;
    w_we        = r_we;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_cpu_rdata = r_cpu_rdata;
    w_dma_rdata = r_dma_rdata;
    w_err       = r_err;
    case (r_state)
      S_IDLE: begin
        w_wait = '0;
        w_err  = 1'b0;
        if (cpu_req && (!dma_req || r_last_dma)) begin
          w_state    = S_CPU_BUSY;
          w_last_dma = 1'b0;
          w_we       = cpu_we;
          w_addr     = cpu_addr;
          w_wdata    = cpu_wdata;
        end else if (dma_req) begin
          w_state    = S_DMA_BUSY;
          w_last_dma = 1'b1;
          w_we       = 1'b0;
          w_addr     = dma_addr;
          w_wdata    = '0;
        end
      end
      S_CPU_BUSY, S_DMA_BUSY: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (mem_ack) begin
          if (r_state == S_CPU_BUSY) w_cpu_rdata = mem_rdata;
          else                       w_dma_rdata = mem_rdata;
          w_err   = 1'b0;
          w_state = (r_state == S_CPU_BUSY) ? S_CPU_DONE : S_DMA_DONE;
        end else if (r_wait == WAIT_LAST) begin
          if (r_state == S_CPU_BUSY) w_cpu_rdata = 32'hFFFF_FFFF;
          else                       w_dma_rdata = 32'hFFFF_FFFF;
          w_err   = 1'b1;
          w_state = (r_state == S_CPU_BUSY) ? S_CPU_DONE : S_DMA_DONE;
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end
      S_CPU_DONE, S_DMA_DONE: w_state = S_IDLE;
      default:                w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_dma  <= 1'b1;
      r_wait      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_last_dma  <= w_last_dma;
      r_wait      <= w_wait;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_cpu_rdata <= w_cpu_rdata;
      r_dma_rdata <= w_dma_rdata;
      r_err       <= w_err;
    end
  end

  assign w_busy    = (r_state == S_CPU_BUSY) || (r_state == S_DMA_BUSY);
  assign mem_en    = w_busy;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_ready = (r_state == S_CPU_DONE);
  assign dma_ready = (r_state == S_DMA_DONE);
  assign bus_err   = r_err && (cpu_ready || dma_ready);
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign state_out = r_state;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: directed scenarios then randomized accesses,
// checked against a transaction-level model of grant order, latency and returned data.
module tb_mio_bus_arbiter;

  localparam int MW = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, dma_ready, mem_en, mem_we, bus_err;
  logic [2:0]  state_out;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit          m_last_dma;
  logic [31:0] m_cpu_rdata, m_dma_rdata, m_bus_addr;

  mio_bus_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .state_out(state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_state"}, 32'(state_out), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
    chk({tag, "_dma_ready"}, 32'(dma_ready), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, m_cpu_rdata);
    chk({tag, "_dma_rdata"}, dma_rdata, m_dma_rdata);
    chk({tag, "_mem_addr"}, mem_addr, m_bus_addr);
  endtask

  // One complete access, starting and ending in an IDLE cycle. ack_dly >= MW means no ack.
  task automatic access(input string tag, input bit want_cpu, input bit want_dma,
                        input logic cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
                        input logic [31:0] daddr, input logic [31:0] ackd, input int ack_dly);
    bit          own_cpu, acked;
    logic        exp_we;
    logic [31:0] exp_addr, exp_rdata;
    int          en_cnt;
    idle_checks({tag, "_idle"});
    cpu_req = want_cpu; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwdata;
    dma_req = want_dma; dma_addr = daddr;
    own_cpu    = want_cpu && (!want_dma || m_last_dma);
    m_last_dma = !own_cpu;
    exp_addr   = own_cpu ? caddr : daddr;
    exp_we     = own_cpu ? cwe : 1'b0;
    m_bus_addr = exp_addr;
    acked  = 1'b0;
    en_cnt = 0;
    step();
    for (int cyc = 0; cyc < MW; cyc++) begin
      chk({tag, "_busy_en"}, 32'(mem_en), 32'd1);
      chk({tag, "_busy_state"}, 32'(state_out), own_cpu ? 32'd1 : 32'd2);
      chk({tag, "_busy_addr"}, mem_addr, exp_addr);
      chk({tag, "_busy_we"}, 32'(mem_we), 32'(exp_we));
      if (exp_we) chk({tag, "_busy_wdata"}, mem_wdata, cwdata);
      chk({tag, "_busy_ready"}, 32'(cpu_ready | dma_ready), 32'd0);
      if (mem_en === 1'b1) en_cnt++;
      if (cyc == 0) begin
        cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom); dma_addr = $urandom;
      end
      if (cyc == ack_dly) begin
        mem_ack = 1'b1; mem_rdata = ackd; acked = 1'b1;
      end
      step();
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (acked) break;
    end
    exp_rdata = acked ? ackd : 32'hFFFF_FFFF;
    if (own_cpu) m_cpu_rdata = exp_rdata;
    else         m_dma_rdata = exp_rdata;
    chk({tag, "_en_cycles"}, 32'(en_cnt), acked ? 32'(ack_dly + 1) : 32'(MW));
    chk({tag, "_done_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_done_state"}, 32'(state_out), own_cpu ? 32'd3 : 32'd4);
    chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'(own_cpu));
    chk({tag, "_dma_ready"}, 32'(dma_ready), 32'(!own_cpu));
    chk({tag, "_bus_err"}, 32'(bus_err), 32'(!acked));
    chk({tag, "_cpu_rdata"}, cpu_rdata, m_cpu_rdata);
    chk({tag, "_dma_rdata"}, dma_rdata, m_dma_rdata);
    step();
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_addr = 0; mem_ack = 0; mem_rdata = 0;
    m_last_dma = 1'b1; m_cpu_rdata = 0; m_dma_rdata = 0; m_bus_addr = 0;
    step();
    idle_checks("reset");
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    step();
    reset = 1'b0;
    step();

    access("cpu_read", 1, 0, 1'b0, 32'h100, 32'h0, 32'h0, 32'hDEAD_BEEF, 2);
    cpu_req = 0;
    access("cpu_write", 1, 0, 1'b1, 32'h204, 32'h1234_5678, 32'h0, 32'h0, 0);
    access("dma_timeout", 0, 1, 1'b0, 32'h0, 32'h0, 32'h800, 32'h5555_AAAA, MW + 3);
    access("ack_at_limit", 1, 0, 1'b0, 32'h40, 32'h0, 32'h0, 32'hCAFE_F00D, MW - 1);
    for (int i = 0; i < 4; i++)
      access("contend", 1, 1, 1'($urandom), $urandom, $urandom, $urandom, $urandom, i);

    // Stray ack while idle must be ignored.
    cpu_req = 0; dma_req = 0;
    idle_checks("stray_pre");
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_ack = 1'b0;
    idle_checks("stray_post");

    // Reset in the middle of a CPU access.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
    step();
    chk("rst_busy_en", 32'(mem_en), 32'd1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("rst_async_en", 32'(mem_en), 32'd0);
    chk("rst_async_state", 32'(state_out), 32'd0);
    m_last_dma = 1'b1; m_cpu_rdata = 0; m_dma_rdata = 0; m_bus_addr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_ready", 32'(cpu_ready | dma_ready), 32'd0);
    end
    reset = 1'b0;
    access("post_reset", 1, 1, 1'b0, 32'h44, 32'h0, 32'h88, 32'h7777_1111, 1);

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        cpu_req = 0; dma_req = 0;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        step();
        mem_ack = 1'b0;
        idle_checks("rand_idle");
      end else begin
        access("rand", sel[0], sel[1], 1'($urandom), $urandom, $urandom, $urandom, $urandom,
               $urandom_range(0, MW + 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_bus_arbiter.md
MIO_BUS_ARBITER -- requirements
Module: mio_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum cycles without mem_ack before an access is aborted.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-004 SHALL have port cpu_req  in  1: CPU access request, held until cpu_ready.
REQ-005 SHALL have port cpu_we  in  1: CPU access is a write (1) or a read (0).
REQ-006 SHALL have port cpu_addr  in  32: CPU byte address.
REQ-007 SHALL have port cpu_wdata  in  32: CPU write data.
REQ-008 SHALL have port cpu_rdata  out  32: CPU read data, valid while cpu_ready=1.
REQ-009 SHALL have port cpu_ready  out  1: one-cycle CPU completion pulse.
REQ-010 SHALL have port dma_req  in  1: DMA/VGA read request, held until dma_ready.
REQ-011 SHALL have port dma_addr  in  32: DMA read address.
REQ-012 SHALL have port dma_rdata  out  32: DMA read data, valid while dma_ready=1.
REQ-013 SHALL have port dma_ready  out  1: one-cycle DMA completion pulse.
REQ-014 SHALL have port mem_en  out  1: memory bus access strobe.
REQ-015 SHALL have port mem_we  out  1: memory bus write enable.
REQ-016 SHALL have port mem_addr  out  32: memory bus address.
REQ-017 SHALL have port mem_wdata  out  32: memory bus write data.
REQ-018 SHALL have port mem_rdata  in  32: memory bus read data, valid with mem_ack.
REQ-019 SHALL have port mem_ack  in  1: memory completion, may arrive any cycle mem_en=1.
REQ-020 SHALL have port bus_err  out  1: qualifies a ready pulse as a timed-out access.
REQ-021 SHALL have port state_out  out  3: current FSM state encoding, for debug.

Function
REQ-022 SHALL implement the states IDLE=0, CPU_BUSY=1, DMA_BUSY=2, CPU_DONE=3, DMA_DONE=4; codes 5-7 SHALL go to IDLE.
REQ-023 IDLE: when only one requester is active, the FSM SHALL move to that requester's BUSY state; when neither is active it SHALL stay in IDLE.
REQ-024 IDLE with cpu_req=dma_req=1: SHALL grant opposite of the last_grant flag (round-robin); after reset last_grant SHALL equal DMA, so the CPU wins first.
REQ-025 On entering BUSY, SHALL latch addr, we and wdata (DMA: we=0) into internal registers; mem_addr, mem_we and mem_wdata SHALL drive the latched values; last_grant SHALL update.
REQ-026 BUSY: mem_en=1 every cycle until mem_ack or timeout; requester input changes during BUSY SHALL be ignored.
REQ-027 BUSY with mem_ack=1: SHALL capture mem_rdata into the owner's rdata register and go to the owner's DONE state.
REQ-028 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; when it reaches MAX_WAIT, the FSM SHALL go to DONE with bus_err=1 and rdata=32'hFFFF_FFFF.
REQ-029 mem_ack on the same cycle the counter reaches MAX_WAIT: ack SHALL win, bus_err=0.
REQ-030 DONE: SHALL assert the owner's ready for exactly one cycle (bus_err for that cycle) with mem_en=0, then go to IDLE.
REQ-031 Latency: req sampled in IDLE at edge N -> mem_en from cycle N+1; ack sampled at edge M -> ready high in cycle M+1; minimum 3 cycles from req to ready.
REQ-032 A requester SHALL drop req in the cycle after ready; req still high in IDLE SHALL be treated as a new request.
REQ-033 The rdata registers SHALL hold their last value outside ready cycles.
REQ-034 mem_ack while not in BUSY SHALL be ignored.
REQ-035 The design SHALL be width-exact: no truncation of 32-bit data and no sign extension.

Reset
REQ-036 reset=1 SHALL force, asynchronously: state=IDLE, last_grant=DMA, wait counter=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, cpu_rdata=dma_rdata=0, cpu_ready=dma_ready=bus_err=0, state_out=0.
REQ-037 Reset mid-access SHALL abort the access with no ready pulse; the first grant after release SHALL follow REQ-024.

Verification
REQ-038 CPU read: cpu_req=1, cpu_we=0, addr=0x100, ack 2 cycles after mem_en with rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, cpu_ready pulse with cpu_rdata=0xDEADBEEF, bus_err=0.
REQ-039 CPU write: addr=0x204, wdata=0x12345678, ack in first mem_en cycle -> mem_we=1, mem_wdata=0x12345678, cpu_ready 3 cycles after req.
REQ-040 Contention: cpu_req and dma_req held high for 4 accesses -> grant order CPU, DMA, CPU, DMA.
REQ-041 Timeout: DMA request, mem_ack held low -> mem_en high for MAX_WAIT cycles, then dma_ready=1, bus_err=1, dma_rdata=0xFFFFFFFF, then IDLE.
REQ-042 Reset in CPU_BUSY: assert reset -> mem_en=0 immediately, no cpu_ready; after release with both requests high, the CPU is granted.
REQ-043 Stray mem_ack in IDLE, and cpu_addr changed during BUSY -> no state change, and mem_addr keeps the latched value.
